// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter shared types: sequencer states and requester count.
// Imported by the arbiter top and the two-way picker.
package rom_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND0 = 2'd1,
    PEND1 = 2'd2
  } state_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of rom_arbiter: fetch (0) and load (1) ports.
// master = requesters, slave = arbiter.
interface rom_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_addr, rsp0_ready,
    output req1_valid, req1_addr, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, rsp0_ready,
    input  req1_valid, req1_addr, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/rom_arb_pick2.sv
// Combinational two-way picker: one-hot grant from valid[1:0].
// On a tie, ptr=0 favours port 0 and ptr=1 favours port 1.
module rom_arb_pick2
  import rom_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (1'b1)
      (valid == 2'b11): grant = ptr ? 2'b10 : 2'b01;
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      default:          grant = '0;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter/sequencer for the single-ported boot ROM.
// Define ROM_ARB_RR_EN for round-robin ties; default is fixed priority.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_arbiter_if.slave          bus,
  output logic                  rom_ce,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  state_t             state;
  logic               ptr;
  logic               free;
  logic [NUM_REQ-1:0] valid;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] grant;

  assign bus.rsp0_valid = (state == PEND0);
  assign bus.rsp1_valid = (state == PEND1);
  assign bus.rsp0_data  = rom_dout;
  assign bus.rsp1_data  = rom_dout;

  // The slot frees in the same cycle the pending response handshakes.
  assign free = (state == IDLE)
              | (bus.rsp0_valid & bus.rsp0_ready)
              | (bus.rsp1_valid & bus.rsp1_ready);

  assign valid = {bus.req1_valid, bus.req0_valid};

  rom_arb_pick2 u_pick (
    .valid (valid),
    .ptr   (ptr),
    .grant (pick)
  );

  assign grant = (free && !rst) ? pick : '0;

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign rom_ce         = |grant;
  assign rom_addr       = grant[1] ? bus.req1_addr :
                          grant[0] ? bus.req0_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (grant[0]) begin
      state <= PEND0;
    end else if (grant[1]) begin
      state <= PEND1;
    end else if (free) begin
      state <= IDLE;
    end
  end

`ifdef ROM_ARB_RR_EN
  // Pointer favours the port that did not win the latest grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= grant[0];
    end
  end
`else
  assign ptr = 1'b0;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed plan steps plus random
// traffic, all checked against a transaction-level reference model.
module tb_rom_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;

  rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_ce   (rom_ce),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hA5000000 | {24'h0, a};
  endfunction

  // ROM macro model: registered read, holds while rom_ce is low
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= rom_word(rom_addr);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which port owns the outstanding read, its data,
  // and which port won the latest grant (-1: none since reset).
  int            pend;
  logic [DW-1:0] pend_data;
  int            last;
  int            win;
  bit            m_free;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] exp_addr;
    m_free = (pend < 0) || (pend == 0 && bus.rsp0_ready)
                        || (pend == 1 && bus.rsp1_ready);
    win = -1;
    if (!rst && m_free) begin
      if (bus.req0_valid && bus.req1_valid)
        win = (RR && last == 0) ? 1 : 0;
      else if (bus.req0_valid)
        win = 0;
      else if (bus.req1_valid)
        win = 1;
    end
    exp_addr = (win == 0) ? bus.req0_addr :
               (win == 1) ? bus.req1_addr : '0;
    check("rsp0_valid", {31'b0, bus.rsp0_valid}, {31'b0, pend == 0});
    check("rsp1_valid", {31'b0, bus.rsp1_valid}, {31'b0, pend == 1});
    if (pend == 0) check("rsp0_data", bus.rsp0_data, pend_data);
    if (pend == 1) check("rsp1_data", bus.rsp1_data, pend_data);
    check("req0_ready", {31'b0, bus.req0_ready}, {31'b0, win == 0});
    check("req1_ready", {31'b0, bus.req1_ready}, {31'b0, win == 1});
    check("rom_ce", {31'b0, rom_ce}, {31'b0, win >= 0});
    check("rom_addr", {24'b0, rom_addr}, {24'b0, exp_addr});
  endtask

  task automatic update();
    if (rst) begin
      pend = -1;
      last = -1;
    end else if (win >= 0) begin
      pend      = win;
      pend_data = rom_word(win == 0 ? bus.req0_addr : bus.req1_addr);
      last      = win;
    end else if (m_free) begin
      pend = -1;
    end
  endtask

  // Inputs are set just after a falling edge; one step = one clock.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  bit hold0, hold1;
  int exp_port;

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    pend = -1;
    last = -1;
    win  = -1;
    @(negedge clk);
    do_reset();

    // 1: single fetch
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h10;
    step();
    bus.req0_valid = 1'b0;
    check("t1_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
    check("t1_rsp0_data", bus.rsp0_data, 32'hA5000010);
    check("t1_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
    step();

    // 2: simultaneous requests from a fresh reset
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h01;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 8'h02;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_port = RR ? (k % 2) : 0;
      check("t2_rsp0_valid", {31'b0, bus.rsp0_valid},
            {31'b0, exp_port == 0});
      check("t2_data", exp_port == 0 ? bus.rsp0_data : bus.rsp1_data,
            exp_port == 0 ? 32'hA5000001 : 32'hA5000002);
    end
    idle_inputs();
    step();

    // 3: back-to-back streaming on port 1
    for (int i = 0; i < 16; i++) begin
      bus.req1_valid = 1'b1;
      bus.req1_addr  = AW'(i);
      step();
      check("t3_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd1);
      check("t3_rsp1_data", bus.rsp1_data, 32'hA5000000 + 32'(i));
    end
    idle_inputs();
    step();

    // 4: response stall on port 0 blocks port 1
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h20;
    bus.rsp0_ready = 1'b0;
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 8'h33;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_rsp0_data", bus.rsp0_data, 32'hA5000020);
      check("t4_rom_ce", {31'b0, rom_ce}, 32'd0);
      check("t4_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
      step();
    end
    bus.rsp0_ready = 1'b1;
    step();
    bus.req1_valid = 1'b0;
    check("t4_rsp1_data", bus.rsp1_data, 32'hA5000033);
    step();

    // 5: reset while PEND1 drops the response
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 8'h44;
    bus.rsp1_ready = 1'b0;
    step();
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    step();
    check("t5_rsp1_dropped", {31'b0, bus.rsp1_valid}, 32'd0);
    rst = 1'b0;
    step();
    check("t5_rsp1_still_0", {31'b0, bus.rsp1_valid}, 32'd0);
    bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h55;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 8'h66;
    step();
    check("t5_tie_port0", {31'b0, bus.rsp0_valid}, 32'd1);
    check("t5_tie_data", bus.rsp0_data, 32'hA5000055);
    idle_inputs();
    step();

    // 6: idle outputs
    for (int k = 0; k < 10; k++) begin
      step();
      check("t6_rom_ce", {31'b0, rom_ce}, 32'd0);
      check("t6_rom_addr", {24'b0, rom_addr}, 32'd0);
      check("t6_rsp_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    end

    // Random traffic; an ungranted request is held stable
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req0_addr  = AW'($urandom);
      end
      if (!hold1) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req1_addr  = AW'($urandom);
      end
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step();
      hold0 = bus.req0_valid && (win != 0);
      hold1 = bus.req1_valid && (win != 1);
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
